pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage core. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, taken-branch redirects, instruction-fetch waits, data-memory waits and multi-cycle divide in EX. The flush outputs drive pipeline-register flush pins, which load NOP (ADDI x0,x0,0) and pc=0.

---
 rtl/pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the PC, IF/ID, ID/EX and EX/MEM registers of the 5-stage core.
// Define PIPE_CTRL_PERF_EN to build the stall_count / flush_count performance counters.
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             ex_div_start,
   input  logic             div_done,
   input  logic             imem_ready,
   input  logic             dmem_busy,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             ex_mem_flush,
   output logic [2:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      MEM_WAIT = 3'd1,
      DIV_WAIT = 3'd2,
      FLUSH    = 3'd3
   } state_t;

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   logic [1:0] fcnt, fcnt_nxt;
   logic       luh;

   assign luh = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

   assign ctrl_state = state;

   always_comb begin
      // NOTE: every output and next-state value gets a default first so no path infers a latch.
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b1;
      ex_mem_flush = 1'b0;
      state_nxt    = state;
      fcnt_nxt     = fcnt;

      case (state)
         // MEM_WAIT re-runs the RUN priority list the cycle memory frees up, so no dead cycle.
         RUN, MEM_WAIT: begin
            if (dmem_busy) begin
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               id_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
               state_nxt = MEM_WAIT;
            end else if (ex_branch_taken) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt = FLUSH;
                  fcnt_nxt  = FLUSH_LOAD;
               end else begin
                  state_nxt = RUN;
               end
            end else if (ex_div_start) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
               if (div_done) begin
                  state_nxt = RUN;
               end else begin
                  ex_mem_flush = 1'b1;
                  state_nxt    = DIV_WAIT;
               end
            end else begin
               state_nxt = RUN;
               if (luh) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end else if (!imem_ready) begin
                  pc_en       = 1'b0;
                  if_id_flush = 1'b1;
               end
            end
         end

         DIV_WAIT: begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            if (dmem_busy) begin
               ex_mem_en = 1'b0;
            end else if (div_done) begin
               state_nxt = RUN;
            end else begin
               ex_mem_flush = 1'b1;
            end
         end

         FLUSH: begin
            if (dmem_busy) begin
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               id_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
            end else begin
               if_id_flush = 1'b1;
               pc_en       = imem_ready;
               if (fcnt <= 2'd1) begin
                  state_nxt = RUN;
                  fcnt_nxt  = 2'd0;
               end else begin
                  fcnt_nxt = fcnt - 2'd1;
               end
            end
         end

         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         fcnt  <= 2'd0;
      end else begin
         // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic             redirect;
   logic [CNT_W-1:0] stall_q, flush_q;

   // A redirect is only honoured on a RUN-evaluation cycle with memory free.
   assign redirect = ((state == RUN) || (state == MEM_WAIT)) && !dmem_busy && ex_branch_taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
         if (redirect && (flush_q != '1))
            flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_count = stall_q;
   assign flush_count = flush_q;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3) against a phase-based reference model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
   localparam int FC      = 3;
   localparam int CNT_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;
   } ctl_t;
   localparam ctl_t DEF = ctl_t'(7'b1101010);

   typedef enum int {STREAM, MEM_HOLD, DIV_HOLD, REDIRECT} phase_t;

   logic clk, rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_div_start;
   logic div_done, imem_ready, dmem_busy;
   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;
   logic [2:0] ctrl_state;
   logic [CNT_W-1:0] stall_count, flush_count;

   int n_cmp = 0;
   int n_bad = 0;

   phase_t m_phase   = STREAM;
   int     m_left    = 0;
   int     m_stalls  = 0;
   int     m_flushes = 0;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .ex_div_start(ex_div_start), .div_done(div_done), .imem_ready(imem_ready),
      .dmem_busy(dmem_busy),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
      .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
      .ctrl_state(ctrl_state), .stall_count(stall_count), .flush_count(flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] enc(input phase_t p);
      case (p)
         MEM_HOLD: return 3'd1;
         DIV_HOLD: return 3'd2;
         REDIRECT: return 3'd3;
         default:  return 3'd0;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] exp_cnt(input int v);
`ifdef PIPE_CTRL_PERF_EN
      return v[CNT_W-1:0];
`else
      return '0;
`endif
   endfunction

   task automatic set_idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_div_start = 1'b0;
      div_done = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
   endtask

   task automatic model_reset();
      m_phase = STREAM; m_left = 0; m_stalls = 0; m_flushes = 0;
   endtask

   // Samples the DUT at the falling edge, predicts from the phase model, then advances one clock.
   task automatic tick(output ctl_t e, output ctl_t g, output logic [2:0] es, output logic [2:0] gs);
      bit     luh, run_eval, redirect;
      phase_t np;
      int     nl;
      @(negedge clk);
      g  = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush};
      gs = ctrl_state;
      es = enc(m_phase);
      e  = DEF; np = m_phase; nl = m_left; redirect = 0;
      luh = ex_mem_read && (ex_rd != 0) &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      run_eval = (m_phase == STREAM) || (m_phase == MEM_HOLD && !dmem_busy);
      if (m_phase == MEM_HOLD && dmem_busy) begin
         e = '0;
      end else if (run_eval) begin
         np = STREAM;
         if (dmem_busy) begin
            e = '0; np = MEM_HOLD;
         end else if (ex_branch_taken) begin
            e.if_id_flush = 1; e.id_ex_flush = 1; redirect = 1;
            if (FC > 1) begin np = REDIRECT; nl = FC - 1; end
         end else if (ex_div_start) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0;
            if (!div_done) begin e.ex_mem_flush = 1; np = DIV_HOLD; end
         end else if (luh) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
         end else if (!imem_ready) begin
            e.pc_en = 0; e.if_id_flush = 1;
         end
      end else if (m_phase == DIV_HOLD) begin
         e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0;
         if (dmem_busy) e.ex_mem_en = 0;
         else if (div_done) np = STREAM;
         else e.ex_mem_flush = 1;
      end else begin
         if (dmem_busy) begin
            e = '0;
         end else begin
            e.if_id_flush = 1; e.pc_en = imem_ready;
            nl = m_left - 1;
            if (nl <= 0) begin np = STREAM; nl = 0; end
         end
      end
      if (!e.pc_en && m_stalls < CNT_MAX) m_stalls++;
      if (redirect && m_flushes < CNT_MAX) m_flushes++;
      @(posedge clk); #1;
      m_phase = np; m_left = nl;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      model_reset();
      #1;
      n_cmp++; if (ctrl_state !== 3'd0) begin n_bad++; $display("FAIL reset ctrl_state got %0d exp 0", ctrl_state); end
      n_cmp++; if (stall_count !== '0) begin n_bad++; $display("FAIL reset stall_count got %0d exp 0", stall_count); end
      n_cmp++; if (flush_count !== '0) begin n_bad++; $display("FAIL reset flush_count got %0d exp 0", flush_count); end
      n_cmp++;
      if ({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush} !== DEF) begin
         n_bad++; $display("FAIL reset outputs got %b exp %b", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush}, DEF);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_use();
      ctl_t e, g; logic [2:0] es, gs;
      for (int i = 0; i < 4; i++) begin
         set_idle();
         if (i == 0 || i == 2) begin
            ex_mem_read = 1; id_rs1 = 5'd5; id_uses_rs1 = 1;
            ex_rd = (i == 0) ? 5'd5 : 5'd0;
         end
         tick(e, g, es, gs);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL load_use[%0d] ctl got %b exp %b", i, g, e); end
         n_cmp++; if (gs !== es) begin n_bad++; $display("FAIL load_use[%0d] state got %0d exp %0d", i, gs, es); end
         if (i == 1) begin
            n_cmp++; if (stall_count !== exp_cnt(m_stalls)) begin n_bad++; $display("FAIL load_use stall_count got %0d exp %0d", stall_count, exp_cnt(m_stalls)); end
         end
      end
   endtask

   task automatic test_branch();
      ctl_t e, g; logic [2:0] es, gs;
      for (int i = 0; i < 5; i++) begin
         set_idle();
         ex_branch_taken = (i == 0);
         tick(e, g, es, gs);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL branch[%0d] ctl got %b exp %b", i, g, e); end
         n_cmp++; if (gs !== es) begin n_bad++; $display("FAIL branch[%0d] state got %0d exp %0d", i, gs, es); end
      end
      n_cmp++; if (flush_count !== exp_cnt(m_flushes)) begin n_bad++; $display("FAIL branch flush_count got %0d exp %0d", flush_count, exp_cnt(m_flushes)); end
   endtask

   task automatic test_divide();
      ctl_t e, g; logic [2:0] es, gs;
      for (int i = 0; i < 9; i++) begin
         set_idle();
         ex_div_start = (i == 0);
         div_done     = (i == 6);
         tick(e, g, es, gs);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL divide[%0d] ctl got %b exp %b", i, g, e); end
         n_cmp++; if (gs !== es) begin n_bad++; $display("FAIL divide[%0d] state got %0d exp %0d", i, gs, es); end
      end
      n_cmp++; if (stall_count !== exp_cnt(m_stalls)) begin n_bad++; $display("FAIL divide stall_count got %0d exp %0d", stall_count, exp_cnt(m_stalls)); end
   endtask

   task automatic test_priority();
      ctl_t e, g; logic [2:0] es, gs;
      for (int i = 0; i < 8; i++) begin
         set_idle();
         if (i <= 3) begin
            ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1;
            dmem_busy = (i < 3);
         end
         tick(e, g, es, gs);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL priority[%0d] ctl got %b exp %b", i, g, e); end
         n_cmp++; if (gs !== es) begin n_bad++; $display("FAIL priority[%0d] state got %0d exp %0d", i, gs, es); end
      end
      n_cmp++; if (flush_count !== exp_cnt(m_flushes)) begin n_bad++; $display("FAIL priority flush_count got %0d exp %0d", flush_count, exp_cnt(m_flushes)); end
   endtask

   task automatic test_imem_wait();
      ctl_t e, g; logic [2:0] es, gs;
      int base;
      base = m_stalls;
      for (int i = 0; i < 5; i++) begin
         set_idle();
         imem_ready = (i >= 4);
         tick(e, g, es, gs);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL imem_wait[%0d] ctl got %b exp %b", i, g, e); end
      end
      n_cmp++; if (stall_count !== exp_cnt(base + 4)) begin n_bad++; $display("FAIL imem_wait stall_count got %0d exp %0d", stall_count, exp_cnt(base + 4)); end
   endtask

   task automatic test_async_reset();
      ctl_t e, g; logic [2:0] es, gs;
      for (int i = 0; i < 3; i++) begin
         set_idle();
         ex_div_start = (i == 0);
         tick(e, g, es, gs);
         n_cmp++; if (gs !== es) begin n_bad++; $display("FAIL async_reset[%0d] state got %0d exp %0d", i, gs, es); end
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_cmp++; if (ctrl_state !== 3'd0) begin n_bad++; $display("FAIL async_reset ctrl_state got %0d exp 0", ctrl_state); end
      n_cmp++; if (stall_count !== '0) begin n_bad++; $display("FAIL async_reset stall_count got %0d exp 0", stall_count); end
      n_cmp++; if (flush_count !== '0) begin n_bad++; $display("FAIL async_reset flush_count got %0d exp 0", flush_count); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      set_idle();
      tick(e, g, es, gs);
      n_cmp++; if (g !== DEF) begin n_bad++; $display("FAIL async_reset post ctl got %b exp %b", g, DEF); end
      n_cmp++; if (gs !== 3'd0) begin n_bad++; $display("FAIL async_reset post state got %0d exp 0", gs); end
   endtask

   task automatic test_random();
      ctl_t e, g; logic [2:0] es, gs;
      for (int i = 0; i < 3000; i++) begin
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         ex_rd           = 5'($urandom_range(0, 3));
         id_uses_rs1     = $urandom_range(0, 1) == 1;
         id_uses_rs2     = $urandom_range(0, 1) == 1;
         ex_mem_read     = $urandom_range(0, 2) == 0;
         ex_branch_taken = $urandom_range(0, 7) == 0;
         ex_div_start    = $urandom_range(0, 7) == 0;
         div_done        = $urandom_range(0, 2) == 0;
         imem_ready      = $urandom_range(0, 4) != 0;
         dmem_busy       = $urandom_range(0, 4) == 0;
         tick(e, g, es, gs);
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL random[%0d] ctl got %b exp %b", i, g, e); end
         n_cmp++; if (gs !== es) begin n_bad++; $display("FAIL random[%0d] state got %0d exp %0d", i, gs, es); end
      end
      n_cmp++; if (stall_count !== exp_cnt(m_stalls)) begin n_bad++; $display("FAIL random stall_count got %0d exp %0d", stall_count, exp_cnt(m_stalls)); end
      n_cmp++; if (flush_count !== exp_cnt(m_flushes)) begin n_bad++; $display("FAIL random flush_count got %0d exp %0d", flush_count, exp_cnt(m_flushes)); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_divide();
      test_priority();
      test_imem_wait();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
